// File: rtl/mm_pkg.sv
// ---------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the matrix-multiply sequencer slice:
//   state_t     - sequencer FSM state encoding (3 bits)
//   DEF_*       - default matrix dimensions and MAC pipeline latency
//   clog2_min1  - index width helper that never returns less than 1 bit
// ---------------------------------------------------------------------------
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        DRAIN = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_ROWS    = 2;
    localparam int DEF_INNER   = 2;
    localparam int DEF_COLS    = 2;
    localparam int DEF_MAC_LAT = 1;

    // A dimension of 1 still needs a 1-bit index port, so $clog2 alone is not enough.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/mm_index_counter.sv
// ---------------------------------------------------------------------------
// mm_index_counter
// Nested i/j/k counter for walking C[ROWS x COLS] with INNER k-steps each.
// Ports:
//   clock, reset     - rising-edge clock, synchronous active-low reset
//   clear            - return i, j, k to 0 (start of a new operation)
//   k_step           - advance k, wrapping to 0 after INNER-1
//   elem_step        - advance to the next element in row-major order
//   i, j, k          - current row, column and inner indices
//   k_last           - k is at INNER-1
//   elem_last        - (i, j) is the final element (ROWS-1, COLS-1)
// ---------------------------------------------------------------------------
module mm_index_counter
    import mm_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int INNER = DEF_INNER,
    parameter int COLS  = DEF_COLS
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          k_step,
    input  logic                          elem_step,
    output logic [clog2_min1(ROWS)-1:0]   i,
    output logic [clog2_min1(COLS)-1:0]   j,
    output logic [clog2_min1(INNER)-1:0]  k,
    output logic                          k_last,
    output logic                          elem_last
);

    localparam int RW = clog2_min1(ROWS);
    localparam int CW = clog2_min1(COLS);
    localparam int KW = clog2_min1(INNER);

    localparam logic [RW-1:0] I_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] J_MAX = CW'(COLS - 1);
    localparam logic [KW-1:0] K_MAX = KW'(INNER - 1);

    logic i_last;
    logic j_last;

    assign i_last    = (i == I_MAX);
    assign j_last    = (j == J_MAX);
    assign k_last    = (k == K_MAX);
    assign elem_last = i_last && j_last;

    // k wraps inside an element; j wraps into i at the end of a row.
    // The caller never steps past the final element, so i wrapping is only a safety net.
    always_ff @(posedge clock) begin
        if (!reset) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (clear) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            if (k_step) begin
                k <= k_last ? '0 : k + 1'b1;
            end
            if (elem_step) begin
                if (j_last) begin
                    j <= '0;
                    i <= i_last ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mm_sequencer.sv
// ---------------------------------------------------------------------------
// mm_sequencer
// Control sequencer for C[ROWS x COLS] = A*B (or C += A*B). For each output
// element it issues INNER MAC steps, waits MAC_LAT cycles for the datapath,
// then hands the element to the result store with a valid/ready handshake.
// Ports:
//   clock, reset           - rising-edge clock, synchronous active-low reset
//   start, accumulate      - begin an operation (IDLE only); mode latched at start
//   busy                   - high in every state except IDLE
//   mac_en, mac_first      - MAC step strobe; first k-step of an element
//   c_preload              - latched accumulate mode, only on mac_first
//   a_row, a_col           - A operand indices (i, k)
//   b_row, b_col           - B operand indices (k, j)
//   wr_valid, wr_ready     - result store handshake
//   c_row, c_col           - destination of the element being written
//   done                   - one-cycle pulse after the final element is accepted
// All outputs decode registered state/counters only.
// ---------------------------------------------------------------------------
module mm_sequencer
    import mm_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int INNER   = DEF_INNER,
    parameter int COLS    = DEF_COLS,
    parameter int MAC_LAT = DEF_MAC_LAT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          accumulate,
    output logic                          busy,
    output logic                          mac_en,
    output logic                          mac_first,
    output logic                          c_preload,
    output logic [clog2_min1(ROWS)-1:0]   a_row,
    output logic [clog2_min1(INNER)-1:0]  a_col,
    output logic [clog2_min1(INNER)-1:0]  b_row,
    output logic [clog2_min1(COLS)-1:0]   b_col,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [clog2_min1(ROWS)-1:0]   c_row,
    output logic [clog2_min1(COLS)-1:0]   c_col,
    output logic                          done
);

    localparam int RW = clog2_min1(ROWS);
    localparam int CW = clog2_min1(COLS);
    localparam int KW = clog2_min1(INNER);
    localparam int LW = $clog2(MAC_LAT + 1);

    // Loading MAC_LAT-1 and leaving at 0 gives exactly MAC_LAT drain cycles.
    localparam logic [LW-1:0] DRAIN_INIT = LW'(MAC_LAT - 1);

    state_t          state;
    logic [LW-1:0]   drain;
    logic            acc_mode;

    logic [RW-1:0]   i;
    logic [CW-1:0]   j;
    logic [KW-1:0]   k;
    logic            k_last;
    logic            elem_last;
    logic            idx_clear;
    logic            k_step;
    logic            elem_step;

    assign idx_clear = (state == IDLE) && start;
    assign k_step    = (state == MAC);
    assign elem_step = (state == STORE) && wr_ready && !elem_last;

    mm_index_counter #(
        .ROWS  (ROWS),
        .INNER (INNER),
        .COLS  (COLS)
    ) u_index (
        .clock     (clock),
        .reset     (reset),
        .clear     (idx_clear),
        .k_step    (k_step),
        .elem_step (elem_step),
        .i         (i),
        .j         (j),
        .k         (k),
        .k_last    (k_last),
        .elem_last (elem_last)
    );

    // Sequencer FSM. start is only looked at in IDLE, so pulses during an
    // operation are dropped; a reset abandons whatever was in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            drain    <= '0;
            acc_mode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_mode <= accumulate;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    if (k_last) begin
                        drain <= DRAIN_INIT;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain == '0) begin
                        state <= STORE;
                    end else begin
                        drain <= drain - 1'b1;
                    end
                end
                STORE: begin
                    if (wr_ready) begin
                        state <= elem_last ? DONE : MAC;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign mac_en    = (state == MAC);
    assign mac_first = mac_en && (k == '0);
    assign c_preload = mac_first && acc_mode;
    assign a_row     = i;
    assign a_col     = k;
    assign b_row     = k;
    assign b_col     = j;
    assign wr_valid  = (state == STORE);
    assign c_row     = i;
    assign c_col     = j;
    assign done      = (state == DONE);

endmodule

// File: tb/tb_mm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mm_sequencer
// Two sequencer instances: dut0 with default dimensions (2,2,2,1) and dut1
// with ROWS=3, INNER=1, COLS=2, MAC_LAT=3. Each started operation pushes the
// full expected MAC-step and write streams (row-major walk) into queues; a
// negedge monitor pops and compares them as the DUTs present mac_en and
// accepted writes, and checks drain length, stall stability and done timing.
// ---------------------------------------------------------------------------
module tb_mm_sequencer;

    localparam int R0 = 2, K0 = 2, C0 = 2, L0 = 1;
    localparam int R1 = 3, K1 = 1, C1 = 2, L1 = 3;

    typedef struct {
        int i;
        int k;
        int j;
        int first;
        int pre;
    } mac_exp_t;

    typedef struct {
        int r;
        int c;
    } wr_exp_t;

    typedef struct {
        int busy;
        int mac_en;
        int first;
        int pre;
        int wv;
        int done;
        int ar;
        int ac;
        int br;
        int bc;
        int cr;
        int cc;
    } obs_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [1:0] reset_v = 2'b00;
    logic [1:0] start_v = 2'b00;
    logic [1:0] acc_v   = 2'b00;
    logic [1:0] ready_v = 2'b11;

    logic       busy0, mac_en0, mac_first0, c_preload0, wr_valid0, done0;
    logic [0:0] a_row0, a_col0, b_row0, b_col0, c_row0, c_col0;
    logic       busy1, mac_en1, mac_first1, c_preload1, wr_valid1, done1;
    logic [1:0] a_row1, c_row1;
    logic [0:0] a_col1, b_row1, b_col1, c_col1;

    mm_sequencer dut0 (
        .clock      (clock),
        .reset      (reset_v[0]),
        .start      (start_v[0]),
        .accumulate (acc_v[0]),
        .busy       (busy0),
        .mac_en     (mac_en0),
        .mac_first  (mac_first0),
        .c_preload  (c_preload0),
        .a_row      (a_row0),
        .a_col      (a_col0),
        .b_row      (b_row0),
        .b_col      (b_col0),
        .wr_valid   (wr_valid0),
        .wr_ready   (ready_v[0]),
        .c_row      (c_row0),
        .c_col      (c_col0),
        .done       (done0)
    );

    mm_sequencer #(
        .ROWS    (R1),
        .INNER   (K1),
        .COLS    (C1),
        .MAC_LAT (L1)
    ) dut1 (
        .clock      (clock),
        .reset      (reset_v[1]),
        .start      (start_v[1]),
        .accumulate (acc_v[1]),
        .busy       (busy1),
        .mac_en     (mac_en1),
        .mac_first  (mac_first1),
        .c_preload  (c_preload1),
        .a_row      (a_row1),
        .a_col      (a_col1),
        .b_row      (b_row1),
        .b_col      (b_col1),
        .wr_valid   (wr_valid1),
        .wr_ready   (ready_v[1]),
        .c_row      (c_row1),
        .c_col      (c_col1),
        .done       (done1)
    );

    int checks = 0;
    int errors = 0;

    mac_exp_t mac_q [2][$];
    wr_exp_t  wr_q  [2][$];
    int       done_q[2][$];

    int mon_en     [2] = '{0, 0};
    int first_mac  [2] = '{-1, -1};
    int drain_cnt  [2] = '{0, 0};
    int stall_cnt  [2] = '{0, 0};
    int prev_stall [2] = '{0, 0};
    int prev_wv    [2] = '{0, 0};
    int prev_r     [2] = '{0, 0};
    int prev_c     [2] = '{0, 0};
    int done_cnt   [2] = '{0, 0};
    int op_len     [2] = '{0, 0};
    int op_first   [2] = '{0, 0};
    int issue_cyc  [2] = '{0, 0};
    int ready_mode [2] = '{0, 0};
    int hold_left  [2] = '{0, 0};

    function automatic int dimR(input int n);
        return (n == 0) ? R0 : R1;
    endfunction
    function automatic int dimK(input int n);
        return (n == 0) ? K0 : K1;
    endfunction
    function automatic int dimC(input int n);
        return (n == 0) ? C0 : C1;
    endfunction
    function automatic int dimL(input int n);
        return (n == 0) ? L0 : L1;
    endfunction

    function automatic obs_t get_obs(input int n);
        obs_t o;
        if (n == 0) begin
            o.busy = int'(busy0);      o.mac_en = int'(mac_en0);
            o.first = int'(mac_first0); o.pre = int'(c_preload0);
            o.wv = int'(wr_valid0);    o.done = int'(done0);
            o.ar = int'(a_row0);       o.ac = int'(a_col0);
            o.br = int'(b_row0);       o.bc = int'(b_col0);
            o.cr = int'(c_row0);       o.cc = int'(c_col0);
        end else begin
            o.busy = int'(busy1);      o.mac_en = int'(mac_en1);
            o.first = int'(mac_first1); o.pre = int'(c_preload1);
            o.wv = int'(wr_valid1);    o.done = int'(done1);
            o.ar = int'(a_row1);       o.ac = int'(a_col1);
            o.br = int'(b_row1);       o.bc = int'(b_col1);
            o.cr = int'(c_row1);       o.cc = int'(c_col1);
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkAllZero(input int n, input string tag);
        obs_t o;
        o = get_obs(n);
        checkOutput({tag, "_ctrl"}, o.busy + o.mac_en + o.first + o.pre + o.wv + o.done, 0);
        checkOutput({tag, "_idx"}, o.ar + o.ac + o.br + o.bc + o.cr + o.cc, 0);
    endtask

    task automatic flushModel(input int n);
        mac_q[n].delete();
        wr_q[n].delete();
        done_q[n].delete();
        first_mac[n]  = -1;
        drain_cnt[n]  = 0;
        stall_cnt[n]  = 0;
        prev_stall[n] = 0;
        prev_wv[n]    = 0;
    endtask

    // Reference model: the whole operation as row-major element list with INNER k-steps each.
    task automatic applyStimulus(input int n, input int acc);
        for (int i = 0; i < dimR(n); i++) begin
            for (int j = 0; j < dimC(n); j++) begin
                for (int k = 0; k < dimK(n); k++) begin
                    mac_q[n].push_back('{i, k, j, int'(k == 0), int'(acc != 0 && k == 0)});
                end
                wr_q[n].push_back('{i, j});
            end
        end
        done_q[n].push_back(1);
        acc_v[n]   = (acc != 0);
        start_v[n] = 1'b1;
        @(posedge clock);
        #1;
        issue_cyc[n] = cyc;
        start_v[n]   = 1'b0;
    endtask

    // Waits for done with a cycle budget; optionally pulses start while in MAC/DRAIN
    // and wiggles accumulate, neither of which may affect the running operation.
    task automatic waitDone(input int n, input int budget, input int noise, input int toggle);
        int   base;
        int   seen;
        obs_t o;
        base = done_cnt[n];
        seen = 0;
        for (int t = 0; t < budget && seen == 0; t++) begin
            @(posedge clock);
            #1;
            if (done_cnt[n] != base) begin
                seen = 1;
            end else begin
                o = get_obs(n);
                if (noise != 0 && o.busy != 0 && o.wv == 0 && o.done == 0)
                    start_v[n] = 1'($urandom_range(0, 1));
                else
                    start_v[n] = 1'b0;
                if (toggle != 0)
                    acc_v[n] = 1'($urandom_range(0, 1));
            end
        end
        start_v[n] = 1'b0;
        if (seen == 0) begin
            checkOutput("done_timeout", 0, 1);
        end else begin
            checkOutput("single_done", done_cnt[n] - base, 1);
            o = get_obs(n);
            checkOutput("busy_after_done", o.busy, 0);
        end
    endtask

    // wr_ready driver: tied high, random, or a directed 5-cycle hold on element (0,1).
    always @(posedge clock) begin
        obs_t o;
        #1;
        for (int n = 0; n < 2; n++) begin
            if (ready_mode[n] == 0) begin
                ready_v[n] = 1'b1;
            end else if (ready_mode[n] == 1) begin
                ready_v[n] = ($urandom_range(0, 3) != 0);
            end else begin
                o = get_obs(n);
                if (o.wv != 0 && o.cr == 0 && o.cc == 1 && hold_left[n] > 0) begin
                    ready_v[n] = 1'b0;
                    hold_left[n]--;
                end else begin
                    ready_v[n] = 1'b1;
                end
            end
        end
    end

    // Monitor: compares DUT activity against the queued expectations.
    always @(negedge clock) begin
        obs_t     o;
        mac_exp_t me;
        wr_exp_t  we;
        for (int n = 0; n < 2; n++) begin
            o = get_obs(n);
            if (mon_en[n] != 0) begin
                if (prev_stall[n] != 0) begin
                    checkOutput("stall_wr_valid", o.wv, 1);
                    checkOutput("stall_c_row", o.cr, prev_r[n]);
                    checkOutput("stall_c_col", o.cc, prev_c[n]);
                    checkOutput("stall_mac_en", o.mac_en, 0);
                end
                if (o.busy == 0)
                    checkOutput("idle_quiet", o.mac_en + o.wv + o.done, 0);
                if (o.mac_en != 0) begin
                    if (first_mac[n] < 0) first_mac[n] = cyc;
                    drain_cnt[n] = 0;
                    if (mac_q[n].size() == 0) begin
                        checkOutput("unexpected_mac", 1, 0);
                    end else begin
                        me = mac_q[n].pop_front();
                        checkOutput("mac_a_row", o.ar, me.i);
                        checkOutput("mac_a_col", o.ac, me.k);
                        checkOutput("mac_b_row", o.br, me.k);
                        checkOutput("mac_b_col", o.bc, me.j);
                        checkOutput("mac_first", o.first, me.first);
                        checkOutput("mac_preload", o.pre, me.pre);
                    end
                end else if (o.busy != 0 && o.wv == 0 && o.done == 0) begin
                    drain_cnt[n]++;
                end
                if (o.wv != 0 && prev_wv[n] == 0)
                    checkOutput("drain_cycles", drain_cnt[n], dimL(n));
                if (o.wv != 0 && ready_v[n] == 1'b1) begin
                    if (wr_q[n].size() == 0) begin
                        checkOutput("unexpected_write", 1, 0);
                    end else begin
                        we = wr_q[n].pop_front();
                        checkOutput("wr_c_row", o.cr, we.r);
                        checkOutput("wr_c_col", o.cc, we.c);
                    end
                end
                prev_stall[n] = int'(o.wv != 0 && ready_v[n] == 1'b0);
                if (prev_stall[n] != 0) stall_cnt[n]++;
                prev_wv[n] = o.wv;
                prev_r[n]  = o.cr;
                prev_c[n]  = o.cc;
                if (o.done != 0) begin
                    checkOutput("done_busy", o.busy, 1);
                    op_len[n]   = cyc - first_mac[n];
                    op_first[n] = first_mac[n];
                    if (done_q[n].size() == 0) begin
                        checkOutput("unexpected_done", 1, 0);
                    end else begin
                        void'(done_q[n].pop_front());
                        checkOutput("done_latency", op_len[n],
                                    dimR(n) * dimC(n) * (dimK(n) + dimL(n) + 1) + stall_cnt[n]);
                    end
                    checkOutput("leftover_mac", mac_q[n].size(), 0);
                    checkOutput("leftover_wr", wr_q[n].size(), 0);
                    first_mac[n] = -1;
                    stall_cnt[n] = 0;
                    done_cnt[n]++;
                end
            end
        end
    end

    initial begin
        obs_t o;
        int   found;
        $display("[TB] mm_sequencer bench starting");
        repeat (3) @(posedge clock);
        #1;
        checkAllZero(0, "reset0");
        checkAllZero(1, "reset1");
        reset_v = 2'b11;
        flushModel(0);
        flushModel(1);
        mon_en = '{1, 1};

        // Defaults: MAC right after the start edge, done 16 cycles after the first MAC.
        applyStimulus(0, 0);
        waitDone(0, 100, 0, 0);
        checkOutput("dflt_mac_start", op_first[0], issue_cyc[0]);
        checkOutput("dflt_op_len", op_len[0], 16);

        // INNER=1, MAC_LAT=3; accumulate drops mid-run, preload must stay on.
        applyStimulus(1, 1);
        acc_v[1] = 1'b0;
        waitDone(1, 200, 0, 0);
        checkOutput("inner1_op_len", op_len[1], 30);

        // Five-cycle store stall on element (0,1).
        ready_mode[0] = 2;
        hold_left[0]  = 5;
        applyStimulus(0, 0);
        waitDone(0, 100, 0, 0);
        checkOutput("stall_op_len", op_len[0], 21);
        checkOutput("stall_consumed", hold_left[0], 0);
        ready_mode[0] = 0;

        // start pulses during MAC/DRAIN must be ignored.
        applyStimulus(0, 1);
        waitDone(0, 100, 1, 0);
        applyStimulus(1, 0);
        waitDone(1, 200, 1, 0);
        repeat (10) @(posedge clock);
        #1;

        // Reset while element (1,0) sits in STORE.
        applyStimulus(0, 1);
        found = 0;
        for (int t = 0; t < 100 && found == 0; t++) begin
            @(posedge clock);
            #1;
            o = get_obs(0);
            if (o.wv != 0 && o.cr == 1 && o.cc == 0) found = 1;
        end
        checkOutput("reach_store_1_0", found, 1);
        mon_en[0]  = 0;
        reset_v[0] = 1'b0;
        @(posedge clock);
        #1;
        checkAllZero(0, "midop_reset");
        reset_v[0] = 1'b1;
        flushModel(0);
        mon_en[0] = 1;
        applyStimulus(0, 0);
        waitDone(0, 100, 0, 0);
        checkOutput("restart_mac_start", op_first[0], issue_cyc[0]);
        checkOutput("restart_op_len", op_len[0], 16);

        // Randomized operations: random mode, random wr_ready, start noise, accumulate wiggle.
        ready_mode = '{1, 1};
        for (int it = 0; it < 8; it++) begin
            applyStimulus(it % 2, int'($urandom_range(0, 1)));
            waitDone(it % 2, 600, 1, 1);
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
        end

        repeat (10) @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
